// File: rtl/req_latch_encoder8_if.sv
// Request/offer bundle between a request source/sink and req_latch_encoder8.
// The slave modport is the encoder's view; master is the surrounding logic.
interface req_latch_encoder8_if #(
    parameter int N     = 8,
    parameter int OVF_W = 8
);
    logic [N-1:0]         req_in;
    logic                 clr_all;
    logic                 out_ready;
    logic [2:0]           out_idx;
    logic                 out_valid;
    logic [N-1:0]         pending;
    logic [OVF_W-1:0]     overflow_cnt;

    modport master (
        output req_in,
        output clr_all,
        output out_ready,
        input  out_idx,
        input  out_valid,
        input  pending,
        input  overflow_cnt
    );

    modport slave (
        input  req_in,
        input  clr_all,
        input  out_ready,
        output out_idx,
        output out_valid,
        output pending,
        output overflow_cnt
    );
endinterface

// File: rtl/req_latch_encoder8.sv
// Sticky request latch feeding a highest-index-first valid/ready offer stage.
// Each served bit is cleared on handshake; re-requests of a still-pending bit
// are counted in a saturating lost-request counter.
module req_latch_encoder8 #(
    parameter int N     = 8,
    parameter int OVF_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    req_latch_encoder8_if.slave   bus
);

    logic [N-1:0]     pending_q, pending_d;
    logic             valid_q, valid_d;
    logic [2:0]       idx_q, idx_d;
    logic [OVF_W-1:0] ovf_q;

    logic             fire;
    logic             load;
    logic             lost;
    logic [N-1:0]     served;

    // Handshake decode, pending update and next offer selection
    always_comb begin
        fire      = valid_q & bus.out_ready;
        load      = ~valid_q | fire;
        served    = '0;
        if (fire) begin
            served[idx_q] = 1'b1;
        end
        pending_d = (pending_q & ~served) | bus.req_in;
        // A served bit re-requested in its fire cycle is a fresh event, not a loss
        lost      = |(bus.req_in & pending_q & ~served);
        valid_d   = valid_q;
        idx_d     = idx_q;
        if (load) begin
            valid_d = |pending_d;
            idx_d   = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (pending_d[i]) begin
                    idx_d = 3'(i);
                end
            end
        end
    end

    // State registers: reset, flush, then normal capture/offer/count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ovf_q     <= '0;
        end else if (bus.clr_all) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            if (lost && (ovf_q != '1)) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    assign bus.out_idx      = idx_q;
    assign bus.out_valid    = valid_q;
    assign bus.pending      = pending_q;
    assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_req_latch_encoder8.sv
// Bench for req_latch_encoder8: directed scenarios plus random traffic, with a
// behavioural model feeding an expected-output queue and a separate monitor.
module tb_req_latch_encoder8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    req_latch_encoder8_if #(.N(8), .OVF_W(8)) bus ();

    req_latch_encoder8 #(.N(8), .OVF_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] pend;
        logic       valid;
        logic [2:0] idx;
        int         ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: pending set, offered item, lost-request tally
    logic [7:0] m_pend  = '0;
    logic       m_valid = 1'b0;
    int         m_idx   = 0;
    int         m_ovf   = 0;

    initial begin
        forever begin
            @(posedge clk);
            begin
                logic [7:0] r;
                logic       rdy, clr, rn, fire, lost;
                exp_t       e;
                r   = bus.req_in;
                rdy = bus.out_ready;
                clr = bus.clr_all;
                rn  = rst_n;
                if (!rn) begin
                    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_ovf = 0;
                end else if (clr) begin
                    m_pend = '0; m_valid = 1'b0;
                end else begin
                    fire = m_valid && rdy;
                    lost = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        if (r[i] && m_pend[i] && !(fire && m_idx == i)) lost = 1'b1;
                    end
                    if (fire) m_pend[m_idx] = 1'b0;
                    m_pend = m_pend | r;
                    if (!m_valid || fire) begin
                        m_valid = (m_pend != 0);
                        m_idx   = top_bit(m_pend);
                    end
                    if (lost && m_ovf < 255) m_ovf++;
                end
                e.pend  = m_pend;
                e.valid = m_valid;
                e.idx   = 3'(m_idx);
                e.ovf   = m_ovf;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares every post-edge snapshot against the queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("sb_queue_nonempty", 0, 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pending",  int'(bus.pending),      int'(e.pend));
                check("sb_valid",    int'(bus.out_valid),    int'(e.valid));
                check("sb_idx",      int'(bus.out_idx),      int'(e.idx));
                check("sb_overflow", int'(bus.overflow_cnt), e.ovf);
            end
        end
    end

    // Apply inputs at a falling edge and return at the next falling edge
    task automatic drive(input logic rn, input logic [7:0] r, input logic rdy, input logic clr);
        rst_n         = rn;
        bus.req_in    = r;
        bus.out_ready = rdy;
        bus.clr_all   = clr;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_in = 8'hFF;
        bus.out_ready = 1'b0;
        bus.clr_all = 1'b0;
        @(negedge clk);

        // Reset with requests asserted, then idle
        drive(0, 8'hFF, 0, 0);
        drive(0, 8'hFF, 0, 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_ovf", int'(bus.overflow_cnt), 0);
        check("rst_idx", int'(bus.out_idx), 0);
        repeat (3) drive(1, 8'h00, 0, 0);
        check("idle_valid", int'(bus.out_valid), 0);
        check("idle_pending", int'(bus.pending), 0);

        // Single request, one-cycle latency
        drive(1, 8'h10, 1, 0);
        check("single_valid", int'(bus.out_valid), 1);
        check("single_idx", int'(bus.out_idx), 4);
        drive(1, 8'h00, 1, 0);
        check("single_done_valid", int'(bus.out_valid), 0);
        check("single_done_pend", int'(bus.pending), 0);

        // Priority drain 2,1,0
        drive(1, 8'h07, 1, 0);
        check("drain_idx2", int'(bus.out_idx), 2);
        drive(1, 8'h00, 1, 0);
        check("drain_idx1", int'(bus.out_idx), 1);
        drive(1, 8'h00, 1, 0);
        check("drain_idx0", int'(bus.out_idx), 0);
        check("drain_valid0", int'(bus.out_valid), 1);
        drive(1, 8'h00, 1, 0);
        check("drain_end_valid", int'(bus.out_valid), 0);
        check("drain_end_pend", int'(bus.pending), 0);

        // Backpressure hold, no preemption
        drive(1, 8'h08, 0, 0);
        check("bp_idx3", int'(bus.out_idx), 3);
        drive(1, 8'h80, 0, 0);
        check("bp_hold_idx", int'(bus.out_idx), 3);
        check("bp_pend88", int'(bus.pending), 8'h88);
        drive(1, 8'h00, 1, 0);
        check("bp_next_idx7", int'(bus.out_idx), 7);
        drive(1, 8'h00, 1, 0);
        check("bp_end_valid", int'(bus.out_valid), 0);

        // Overflow counting and saturation
        drive(1, 8'h20, 0, 0);
        check("ovf_offer_idx5", int'(bus.out_idx), 5);
        check("ovf_first_zero", int'(bus.overflow_cnt), 0);
        repeat (3) begin
            drive(1, 8'h20, 0, 0);
            drive(1, 8'h00, 0, 0);
        end
        check("ovf_three", int'(bus.overflow_cnt), 3);
        repeat (300) drive(1, 8'h20, 0, 0);
        check("ovf_saturate", int'(bus.overflow_cnt), 255);

        // Flush with colliding request: counter must stay put
        drive(0, 8'h00, 0, 0);
        check("ovf_reset", int'(bus.overflow_cnt), 0);
        drive(1, 8'hF0, 0, 0);
        check("flush_pre_pend", int'(bus.pending), 8'hF0);
        check("flush_pre_idx", int'(bus.out_idx), 7);
        drive(1, 8'hF1, 1, 1);
        check("flush_pend", int'(bus.pending), 0);
        check("flush_valid", int'(bus.out_valid), 0);
        check("flush_ovf", int'(bus.overflow_cnt), 0);

        // Same-cycle re-request of the served bit
        drive(1, 8'h04, 1, 0);
        check("rereq_offer", int'(bus.out_idx), 2);
        drive(1, 8'h04, 1, 0);
        check("rereq_valid", int'(bus.out_valid), 1);
        check("rereq_idx", int'(bus.out_idx), 2);
        check("rereq_ovf", int'(bus.overflow_cnt), 0);
        drive(1, 8'h00, 1, 0);
        check("rereq_end_valid", int'(bus.out_valid), 0);

        // Random traffic, checked by the scoreboard only
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            logic       rn, rdy, clr;
            r   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            rn  = ($urandom_range(0, 199) != 0);
            drive(rn, r, rdy, clr);
        end
        drive(1, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
